// File: rtl/mem_if_pkg.sv
// ============================================================================
//  Module      : mem_if_pkg
//  Description : Shared types and constants for cache_mem_responder.
//                State set depends on MEM_BURST_EN.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_if_pkg;

    localparam int BL_NUM_BYTES   = 4;
    localparam int c_BL_OFFSET_BITS = $clog2(BL_NUM_BYTES);
    localparam int c_CNT_W        = 4;

`ifdef MEM_BURST_EN
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LOAD_WAIT  = 3'd1,
        STORE_WAIT = 3'd2,
        LOAD_DONE  = 3'd3,
        STORE_DONE = 3'd4,
        LOAD_BURST = 3'd5
    } mem_state_t;
`else
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LOAD_WAIT  = 3'd1,
        STORE_WAIT = 3'd2,
        LOAD_DONE  = 3'd3,
        STORE_DONE = 3'd4
    } mem_state_t;
`endif

endpackage

`default_nettype wire

// File: rtl/cache_mem_responder_if.sv
// ============================================================================
//  Module      : cache_mem_responder_if
//  Description : Cache <-> memory block load/store handshake bundle.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface cache_mem_responder_if #(
    parameter int D_WIDTH  = 32,
    parameter int WIDTH_AD = 16
);
    logic [WIDTH_AD-1:0] address_in;
    logic [D_WIDTH-1:0]  data_in;
    logic [D_WIDTH-1:0]  data_out;
    logic                mem_load_req;
    logic                mem_store_req;
    logic                load_completed;
    logic                store_completed;
    logic                load_toggle;

    modport master (
        output address_in, data_in, mem_load_req, mem_store_req,
        input  data_out, load_completed, store_completed, load_toggle
    );

    modport slave (
        input  address_in, data_in, mem_load_req, mem_store_req,
        output data_out, load_completed, store_completed, load_toggle
    );
endinterface

`default_nettype wire

// File: rtl/mem_block_array.sv
// ============================================================================
//  Module      : mem_block_array
//  Description : Single-port block storage, synchronous write, registered read.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_block_array #(
    parameter int MEM_BLK_AD = 8,
    parameter int D_WIDTH    = 32
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    input  wire logic                  we,
    input  wire logic                  re,
    input  wire logic [MEM_BLK_AD-1:0] idx,
    input  wire logic [D_WIDTH-1:0]    wdata,
    output logic      [D_WIDTH-1:0]    rdata
);
    localparam int c_NUM_BLOCKS = 1 << MEM_BLK_AD;

    logic [D_WIDTH-1:0] r_mem [c_NUM_BLOCKS];
    logic [D_WIDTH-1:0] r_rdata;

    // Storage itself is deliberately left without reset.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[idx] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (re) begin
            r_rdata <= r_mem[idx];
        end
    end

    assign rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/cache_mem_responder.sv
// ============================================================================
//  Module      : cache_mem_responder
//  Description : Fixed-latency memory responder for the cache block protocol.
//                Optional burst beats on loads when MEM_BURST_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module cache_mem_responder
    import mem_if_pkg::*;
#(
    parameter int D_WIDTH    = 32,
    parameter int WIDTH_AD   = 16,
    parameter int MEM_BLK_AD = 8,
    parameter int LATENCY    = 2
) (
    input wire logic              clk,
    input wire logic              rst_n,
    cache_mem_responder_if.slave  bus
);
    localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(LATENCY - 1);

    mem_state_t              r_state, w_state_nxt;
    logic [c_CNT_W-1:0]      r_cnt, w_cnt_nxt;
    logic [MEM_BLK_AD-1:0]   r_idx;
    logic [D_WIDTH-1:0]      r_wdata;
    logic [D_WIDTH-1:0]      r_data_out, w_data_out_nxt;
    logic                    r_load_cmp, w_load_cmp_nxt;
    logic                    r_store_cmp, w_store_cmp_nxt;
    logic                    w_accept;
    logic                    w_mem_we, w_mem_re;
    logic [MEM_BLK_AD-1:0]   w_mem_idx, w_req_idx;
    logic [D_WIDTH-1:0]      w_rdata;
    logic [WIDTH_AD-1:0]     w_addr;
    logic                    w_unused_addr;

`ifdef MEM_BURST_EN
    localparam int c_HALF = D_WIDTH / 2;
    logic r_toggle, w_toggle_nxt;
    logic r_beat, w_beat_nxt;
`endif

    assign w_addr        = bus.address_in;
    assign w_req_idx     = w_addr[MEM_BLK_AD+c_BL_OFFSET_BITS-1:c_BL_OFFSET_BITS];
    assign w_unused_addr = ^w_addr;

    mem_block_array #(
        .MEM_BLK_AD (MEM_BLK_AD),
        .D_WIDTH    (D_WIDTH)
    ) u_array (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (w_mem_we),
        .re    (w_mem_re),
        .idx   (w_mem_idx),
        .wdata (r_wdata),
        .rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_wdata     <= '0;
            r_data_out  <= '0;
            r_load_cmp  <= 1'b0;
            r_store_cmp <= 1'b0;
`ifdef MEM_BURST_EN
            r_toggle    <= 1'b0;
            r_beat      <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_data_out  <= w_data_out_nxt;
            r_load_cmp  <= w_load_cmp_nxt;
            r_store_cmp <= w_store_cmp_nxt;
`ifdef MEM_BURST_EN
            r_toggle    <= w_toggle_nxt;
            r_beat      <= w_beat_nxt;
`endif
            if (w_accept) begin
                r_idx   <= w_req_idx;
                r_wdata <= bus.data_in;
            end
        end
    end

    // The array is read at acceptance and every wait cycle, so its registered
    // output already holds the block when the countdown reaches zero.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_data_out_nxt  = r_data_out;
        w_load_cmp_nxt  = 1'b0;
        w_store_cmp_nxt = 1'b0;
        w_accept        = 1'b0;
        w_mem_we        = 1'b0;
        w_mem_re        = 1'b0;
        w_mem_idx       = r_idx;
`ifdef MEM_BURST_EN
        w_toggle_nxt    = r_toggle;
        w_beat_nxt      = r_beat;
`endif
        case (r_state)
            IDLE: begin
                w_mem_idx = w_req_idx;
                if (bus.mem_store_req) begin
                    w_accept    = 1'b1;
                    w_state_nxt = STORE_WAIT;
                    w_cnt_nxt   = c_CNT_INIT;
                end else if (bus.mem_load_req) begin
                    w_accept    = 1'b1;
                    w_mem_re    = 1'b1;
                    w_state_nxt = LOAD_WAIT;
                    w_cnt_nxt   = c_CNT_INIT;
                end
            end
            STORE_WAIT: begin
                if (r_cnt == '0) begin
                    w_mem_we        = 1'b1;
                    w_state_nxt     = STORE_DONE;
                    w_store_cmp_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            LOAD_WAIT: begin
                w_mem_re = 1'b1;
                if (r_cnt == '0) begin
`ifdef MEM_BURST_EN
                    w_state_nxt    = LOAD_BURST;
                    w_data_out_nxt = {{c_HALF{1'b0}}, w_rdata[c_HALF-1:0]};
                    w_toggle_nxt   = ~r_toggle;
                    w_beat_nxt     = 1'b0;
`else
                    w_state_nxt    = LOAD_DONE;
                    w_data_out_nxt = w_rdata;
                    w_load_cmp_nxt = 1'b1;
`endif
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
`ifdef MEM_BURST_EN
            LOAD_BURST: begin
                if (!r_beat) begin
                    w_data_out_nxt = {{c_HALF{1'b0}}, w_rdata[D_WIDTH-1:c_HALF]};
                    w_toggle_nxt   = ~r_toggle;
                    w_beat_nxt     = 1'b1;
                end else begin
                    w_data_out_nxt = w_rdata;
                    w_state_nxt    = LOAD_DONE;
                    w_load_cmp_nxt = 1'b1;
                end
            end
`endif
            LOAD_DONE: begin
                if (bus.mem_load_req) begin
                    w_load_cmp_nxt = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            STORE_DONE: begin
                if (bus.mem_store_req) begin
                    w_store_cmp_nxt = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign bus.data_out        = r_data_out;
    assign bus.load_completed  = r_load_cmp;
    assign bus.store_completed = r_store_cmp;
`ifdef MEM_BURST_EN
    assign bus.load_toggle     = r_toggle;
`else
    assign bus.load_toggle     = 1'b0;
`endif

endmodule

`default_nettype wire
